// File: rtl/render_sequencer.sv
// render_sequencer: per-frame controller between triangle memory, rasterizer
// and display. Each frame it swaps buffers, clears the back buffer, streams
// triangles over a dv/last handshake and waits for the rasterizer to finish.
// Frame starts that arrive while a frame is in flight are reported as drops.
//
// Optional feature: define RENDER_SEQ_STATS_EN to add the saturating 16-bit
// o_frames_rendered / o_frames_dropped counters.
//
// Triangle memory read data (i_v*) is captured on the clock edge that leaves
// FETCH, i.e. one cycle after o_tri_idx is presented. This gives dv two
// cycles after i_clear_ready and a two-cycle-per-triangle steady state.

module render_sequencer #(
  parameter int DATAWIDTH     = 12,
  parameter int TRI_COUNT_MAX = 64,
  parameter int TRI_IDX_WIDTH = $clog2(TRI_COUNT_MAX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_frame_start,
  input  logic [TRI_IDX_WIDTH:0]      i_num_triangles,
  output logic [TRI_IDX_WIDTH-1:0]    o_tri_idx,
  input  logic signed [DATAWIDTH-1:0] i_v0 [3],
  input  logic signed [DATAWIDTH-1:0] i_v1 [3],
  input  logic signed [DATAWIDTH-1:0] i_v2 [3],
  output logic signed [DATAWIDTH-1:0] o_v0 [3],
  output logic signed [DATAWIDTH-1:0] o_v1 [3],
  output logic signed [DATAWIDTH-1:0] o_v2 [3],
  output logic                        o_triangle_dv,
  output logic                        o_triangle_last,
  input  logic                        i_rast_ready,
  input  logic                        i_rast_finished,
  output logic                        o_clear,
  input  logic                        i_clear_ready,
  output logic                        o_swap,
  output logic                        o_busy,
`ifdef RENDER_SEQ_STATS_EN
  output logic [15:0]                 o_frames_rendered,
  output logic [15:0]                 o_frames_dropped,
`endif
  output logic                        o_frame_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_CLEAR,
    S_WAIT_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RAST,
    S_DONE
  } state_t;

  localparam logic [TRI_IDX_WIDTH:0]   LP_N_MAX   = (TRI_IDX_WIDTH+1)'(TRI_COUNT_MAX);
  localparam logic [TRI_IDX_WIDTH:0]   LP_N_ONE   = (TRI_IDX_WIDTH+1)'(1);
  localparam logic [TRI_IDX_WIDTH-1:0] LP_IDX_ONE = TRI_IDX_WIDTH'(1);

  // State and datapath registers
  state_t                   r_state;
  state_t                   w_state_next;
  logic [TRI_IDX_WIDTH:0]   r_n;
  logic [TRI_IDX_WIDTH:0]   w_n_next;
  logic [TRI_IDX_WIDTH-1:0] r_idx;
  logic [TRI_IDX_WIDTH-1:0] w_idx_next;

  // Registered outputs and their next values
  logic r_clear, w_clear_next;
  logic r_swap,  w_swap_next;
  logic r_dv,    w_dv_next;
  logic r_last,  w_last_next;
  logic r_busy,  w_busy_next;
  logic r_drop,  w_drop_next;

  logic signed [DATAWIDTH-1:0] r_v0 [3];
  logic signed [DATAWIDTH-1:0] r_v1 [3];
  logic signed [DATAWIDTH-1:0] r_v2 [3];

  // Decoded conditions
  logic                   w_transfer;
  logic                   w_is_last;
  logic                   w_overrun;
  logic [TRI_IDX_WIDTH:0] w_n_clamped;

  // Count clamp: the memory only holds TRI_COUNT_MAX entries
  assign w_n_clamped = (i_num_triangles > LP_N_MAX) ? LP_N_MAX : i_num_triangles;

  // idx never exceeds N-1, so a plain equality marks the final triangle
  assign w_is_last  = ({1'b0, r_idx} == (r_n - LP_N_ONE));
  assign w_transfer = (r_state == S_ISSUE) && r_dv && i_rast_ready;

  // Any frame start while a frame is in flight is an overrun
  assign w_overrun = i_frame_start &&
                     (r_state == S_SWAP || r_state == S_CLEAR ||
                      r_state == S_WAIT_CLEAR || r_state == S_FETCH ||
                      r_state == S_ISSUE || r_state == S_WAIT_RAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // First frame after reset: nothing to display yet, so no swap
        if (i_frame_start) w_state_next = S_CLEAR;
      end
      S_SWAP: begin
        w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_next = S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR: begin
        if (i_clear_ready) begin
          w_state_next = (r_n == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_transfer) w_state_next = w_is_last ? S_WAIT_RAST : S_FETCH;
      end
      S_WAIT_RAST: begin
        // A coincident frame start is dropped; DONE waits for the next one
        if (i_rast_finished) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (i_frame_start) w_state_next = S_SWAP;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values, all derived from the next state so
  // every output comes straight from a flop
  always_comb begin
    w_n_next     = r_n;
    w_idx_next   = r_idx;
    w_clear_next = (w_state_next == S_CLEAR);
    w_swap_next  = (w_state_next == S_SWAP);
    w_dv_next    = (w_state_next == S_ISSUE);
    w_last_next  = (w_state_next == S_ISSUE) && w_is_last;
    w_busy_next  = !((w_state_next == S_IDLE) || (w_state_next == S_DONE));
    w_drop_next  = w_overrun;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_frame_start) w_n_next = w_n_clamped;
      end
      S_WAIT_CLEAR: begin
        if (i_clear_ready && (r_n != '0)) w_idx_next = '0;
      end
      S_ISSUE: begin
        if (w_transfer && !w_is_last) w_idx_next = r_idx + LP_IDX_ONE;
      end
      default: begin
      end
    endcase
  end

  // Datapath and control output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n     <= '0;
      r_idx   <= '0;
      r_clear <= 1'b0;
      r_swap  <= 1'b0;
      r_dv    <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_n     <= w_n_next;
      r_idx   <= w_idx_next;
      r_clear <= w_clear_next;
      r_swap  <= w_swap_next;
      r_dv    <= w_dv_next;
      r_last  <= w_last_next;
      r_busy  <= w_busy_next;
      r_drop  <= w_drop_next;
    end
  end

  // Vertex registers: loaded once per triangle, held stable through ISSUE
  for (genvar gi = 0; gi < 3; gi++) begin : g_vtx
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v0[gi] <= '0;
        r_v1[gi] <= '0;
        r_v2[gi] <= '0;
      end else if (r_state == S_FETCH) begin
        r_v0[gi] <= i_v0[gi];
        r_v1[gi] <= i_v1[gi];
        r_v2[gi] <= i_v2[gi];
      end
    end

    assign o_v0[gi] = r_v0[gi];
    assign o_v1[gi] = r_v1[gi];
    assign o_v2[gi] = r_v2[gi];
  end

  assign o_tri_idx       = r_idx;
  assign o_triangle_dv   = r_dv;
  assign o_triangle_last = r_last;
  assign o_clear         = r_clear;
  assign o_swap          = r_swap;
  assign o_busy          = r_busy;
  assign o_frame_drop    = r_drop;

`ifdef RENDER_SEQ_STATS_EN
  logic [15:0] r_frames_rendered;
  logic [15:0] r_frames_dropped;
  logic        w_done_entry;

  assign w_done_entry = (w_state_next == S_DONE) && (r_state != S_DONE);

  // Saturating frame statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames_rendered <= '0;
      r_frames_dropped  <= '0;
    end else begin
      if (w_done_entry && (r_frames_rendered != 16'hFFFF)) begin
        r_frames_rendered <= r_frames_rendered + 16'd1;
      end
      if (w_drop_next && (r_frames_dropped != 16'hFFFF)) begin
        r_frames_dropped <= r_frames_dropped + 16'd1;
      end
    end
  end

  assign o_frames_rendered = r_frames_rendered;
  assign o_frames_dropped  = r_frames_dropped;
`endif

endmodule

// File: doc/render_sequencer.md
# render_sequencer

Per-frame controller sitting between the triangle memory, the `rasterizer` and the `display` block. On each frame-start pulse it swaps the display buffers, clears the back buffer, streams the frame's triangles into the rasterizer over its `dv`/`last` handshake, and waits for `finished`. It also flags frame starts that arrive before rendering is complete.

## Interface

- `DATAWIDTH`, 12: signed vertex component width; must match the rasterizer.
- `TRI_COUNT_MAX`, 64: triangle memory depth.
- `TRI_IDX_WIDTH`, `$clog2(TRI_COUNT_MAX)`: triangle address width.

Ports:

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_frame_start` in 1: one-cycle pulse at vertical blank start, already in the `clk` domain.
- `i_num_triangles` in `TRI_IDX_WIDTH+1`: triangle count for the frame; sampled only when a frame starts.
- `o_tri_idx` out `TRI_IDX_WIDTH`: triangle memory read address.
- `i_v0`, `i_v1`, `i_v2` in signed `DATAWIDTH` [3]: triangle memory read data, valid 1 cycle after `o_tri_idx`.
- `o_v0`, `o_v1`, `o_v2` out signed `DATAWIDTH` [3]: vertices to the rasterizer.
- `o_triangle_dv` out 1: triangle valid.
- `o_triangle_last` out 1: marks the final triangle of the frame.
- `i_rast_ready` in 1: rasterizer accepts a triangle.
- `i_rast_finished` in 1: pulse when the rasterizer has completed its last triangle.
- `o_clear` out 1: one-cycle back-buffer clear request.
- `i_clear_ready` in 1: clear complete / display idle.
- `o_swap` out 1: one-cycle buffer swap request.
- `o_busy` out 1: high when the state is not IDLE or DONE.
- `o_frame_drop` out 1: one-cycle pulse on an overrun.

## Operation

- Reset: state IDLE. Every output is 0, including `o_tri_idx` and all `o_v*`. Count register `N`=0, index `idx`=0.
- Frame start: `N` latches `min(i_num_triangles, TRI_COUNT_MAX)` on the frame start that triggers SWAP or CLEAR.
- IDLE (nothing rendered yet):
  - On `i_frame_start`: latch `N` and go to CLEAR. No swap is issued.
- SWAP: `o_swap`=1 for this cycle only, then CLEAR.
- CLEAR: `o_clear`=1 for this cycle only, then WAIT_CLEAR.
- WAIT_CLEAR: `i_clear_ready` is sampled from the first cycle of this state.
  - When `i_clear_ready`=1 and `N`==0: go to DONE.
  - When `i_clear_ready`=1 and `N`>0: set `idx`=0 and go to FETCH.
- FETCH: drive `o_tri_idx`=`idx`, then ISSUE.
- ISSUE:
  - On entry, register `i_v*` into `o_v*`.
  - Hold `o_triangle_dv`=1 with `o_triangle_last`=(`idx`==`N`-1).
  - `o_v*` stay stable until the transfer (`o_triangle_dv` && `i_rast_ready`).
  - On transfer: if last, go to WAIT_RAST; otherwise `idx`++ and go to FETCH.
  - `o_triangle_dv` drops in the cycle after the transfer.
- WAIT_RAST: on `i_rast_finished`, go to DONE.
- DONE: on `i_frame_start`, latch `N` and go to SWAP.
- Overrun:
  - `i_frame_start` in CLEAR, WAIT_CLEAR, FETCH, ISSUE, WAIT_RAST or SWAP pulses `o_frame_drop` the next cycle.
  - The pulse is otherwise ignored: the current frame continues, and no swap is issued for it.
- Simultaneous `i_rast_finished` and `i_frame_start` in WAIT_RAST: counts as a drop; the state goes to DONE, which then waits for the following frame start.
- `rst` mid-frame: the block returns to IDLE at once. Any pending `dv`, clear or swap is abandoned, and the next frame starts without a swap.
- `idx` never exceeds `N`-1, so there is no wrap-around.

## Timing

- All outputs are registered.
- Frame start to `o_clear`:
  - From IDLE, `o_clear` is high in cycle T+1.
  - From DONE, `o_swap` is high in T+1 and `o_clear` in T+2.
- `i_clear_ready` seen in cycle C: `o_tri_idx` is valid at C+1 and `o_triangle_dv` rises at C+2.
- Best-case throughput is one triangle per 2 cycles, with `i_rast_ready` held high.
- `i_rast_finished` in cycle F: `o_busy` is 0 from F+1.
- `o_frame_drop` is asserted exactly one cycle after the offending `i_frame_start`.

## Configuration

- `RENDER_SEQ_STATS_EN` defined: adds the ports below. Both counters reset to 0 and saturate at 0xFFFF.
  - `o_frames_rendered` out 16: increments on each entry to DONE.
  - `o_frames_dropped` out 16: increments with each `o_frame_drop`.
- `RENDER_SEQ_STATS_EN` undefined: those ports and counters do not exist. All other behaviour is identical.

## Test plan

- Reset, then frame start with `N`=3, `i_clear_ready`=1, `i_rast_ready`=1:
  - `o_clear` at T+1, no `o_swap`.
  - Three `dv` beats carrying memory entries 0, 1, 2; `last` only on idx 2.
  - After `finished`, `o_busy`=0.
- Back-pressure: `i_rast_ready` low for 5 cycles during triangle 1 -> `o_v*` and `dv` stay stable, no index skipped or repeated.
- Second frame start in DONE -> `o_swap` at T+1 and `o_clear` at T+2, each exactly 1 cycle wide.
- Frame start during WAIT_RAST, including the same cycle as `finished`:
  - `o_frame_drop` pulses at T+1 with no swap.
  - The next frame start swaps normally.
- `i_num_triangles`=0 -> clear then DONE with no `dv`. `i_num_triangles`=100 with `TRI_COUNT_MAX`=64 -> exactly 64 beats, `last` on idx 63.
- `rst` asserted during ISSUE -> next cycle all outputs 0 and state IDLE. With `RENDER_SEQ_STATS_EN` defined, both counters read 0.
